// File: rtl/sdram_port_arbiter_if.sv
// Bundles the two requester ports and the SDRAM pins that the arbiter sits between.
// No logic of its own; timing belongs to the arbiter that uses the slave view.
// Requesters hold req/we/addr/wdata until their ack; the SDRAM side completes with sdram_ready.
interface sdram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16
);
  // Port A: text/ioctl loader
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [7:0]            a_wdata;
  logic                  a_ack;
  logic [7:0]            a_rdata;
  // Port B: CPU-side extended RAM
  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [7:0]            b_wdata;
  logic                  b_ack;
  logic [7:0]            b_rdata;
  // SDRAM controller pins
  logic [ADDR_WIDTH-1:0] sdram_addr;
  logic [7:0]            sdram_din;
  logic                  sdram_rd;
  logic                  sdram_wr;
  logic [7:0]            sdram_dout;
  logic                  sdram_ready;

  // Arbiter's view: takes requests and SDRAM completions, drives acks and strobes.
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata,
    output sdram_addr, sdram_din, sdram_rd, sdram_wr,
    input  sdram_dout, sdram_ready
  );

  // Environment's view: the requesters plus the SDRAM controller.
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata,
    input  sdram_addr, sdram_din, sdram_rd, sdram_wr,
    output sdram_dout, sdram_ready
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide SDRAM port between loader (A) and CPU (B), with watchdog.
// Strobe from the edge after grant; ack/rdata registered one edge after ready; one RECOVER cycle follows.
// One transaction in flight; the losing requester simply waits with req held, a stalled SDRAM is aborted.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk25,
  input  logic                rst,
  sdram_port_arbiter_if.slave bus,
  input  logic                err_clr,
  output logic                busy,
  output logic                timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t                state_q;
  logic                  last_b_q;   // 1: the most recent grant went to port B
  logic                  grant_b_q;  // port owning the command in flight
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            din_q;
  logic                  rd_q;
  logic                  wr_q;
  logic                  a_ack_q;
  logic                  b_ack_q;
  logic [7:0]            a_rdata_q;
  logic [7:0]            b_rdata_q;
  logic                  busy_q;
  logic                  err_q;
  logic [CW-1:0]         cnt_q;

  logic                  pick_b_d;
  logic                  sel_we_d;
  logic [ADDR_WIDTH-1:0] sel_addr_d;
  logic [7:0]            sel_wdata_d;
  logic                  timeout_d;
  logic [CW-1:0]         cnt_d;
  logic [7:0]            rdata_d;

  // Grant choice, selected request fields, watchdog compare and completion data
  always_comb begin
    pick_b_d = 1'b0;
    if (bus.a_req && bus.b_req) begin
      pick_b_d = !last_b_q;  // tie goes to whoever was not served last
    end else begin
      pick_b_d = bus.b_req;
    end
    sel_we_d    = pick_b_d ? bus.b_we    : bus.a_we;
    sel_addr_d  = pick_b_d ? bus.b_addr  : bus.a_addr;
    sel_wdata_d = pick_b_d ? bus.b_wdata : bus.a_wdata;
    timeout_d   = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    // Saturate so a long stall can never wrap back below the abort threshold
    cnt_d       = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    // Ready beats the watchdog; an abort reads back all-ones
    rdata_d     = bus.sdram_ready ? bus.sdram_dout : 8'hFF;
  end

  // Arbitration FSM with all outputs registered
  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_b_q  <= 1'b1;
      grant_b_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      // A watchdog abort later in this block overrides the clear
      if (err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.a_req || bus.b_req) begin
            grant_b_q <= pick_b_d;
            last_b_q  <= pick_b_d;
            we_q      <= sel_we_d;
            addr_q    <= sel_addr_d;
            din_q     <= sel_wdata_d;
            rd_q      <= !sel_we_d;
            wr_q      <= sel_we_d;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.sdram_ready || timeout_d) begin
            if (!we_q) begin
              if (grant_b_q) begin
                b_rdata_q <= rdata_d;
              end else begin
                a_rdata_q <= rdata_d;
              end
            end
            a_ack_q <= !grant_b_q;
            b_ack_q <= grant_b_q;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            if (!bus.sdram_ready) begin
              err_q <= 1'b1;
            end
            state_q <= S_RECOVER;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RECOVER: begin
          // Strobes already low: guarantees a fresh edge for the next command
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.a_ack      = a_ack_q;
  assign bus.b_ack      = b_ack_q;
  assign bus.a_rdata    = a_rdata_q;
  assign bus.b_rdata    = b_rdata_q;
  assign bus.sdram_addr = addr_q;
  assign bus.sdram_din  = din_q;
  assign bus.sdram_rd   = rd_q;
  assign bus.sdram_wr   = wr_q;
  assign busy           = busy_q;
  assign timeout_err    = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized bench for sdram_port_arbiter against a transaction-level model.
// Model predicts grant order, strobe length min(latency, timeout), ack port, rdata and error flag.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sdram_port_arbiter;

  localparam int AW = 16;
  localparam int T  = 8;

  logic clk25 = 1'b0;
  logic rst;
  logic err_clr;
  logic busy;
  logic timeout_err;

  sdram_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  sdram_port_arbiter #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk25      (clk25),
    .rst        (rst),
    .bus        (bus.slave),
    .err_clr    (err_clr),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk25 = ~clk25;

  int tests = 0;
  int fails = 0;

  // Model state
  bit          last_b;
  logic [7:0]  rd_exp [2];
  bit          err_exp;
  bit          pwe    [2];
  logic [15:0] paddr  [2];
  logic [7:0]  pwd    [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int p, input bit req);
    if (p == 0) begin
      bus.a_req = req; bus.a_we = pwe[0]; bus.a_addr = paddr[0]; bus.a_wdata = pwd[0];
    end else begin
      bus.b_req = req; bus.b_we = pwe[1]; bus.b_addr = paddr[1]; bus.b_wdata = pwd[1];
    end
  endtask

  task automatic arm(input int p);
    pwe[p]   = bit'($urandom_range(0, 1));
    paddr[p] = 16'($urandom);
    pwd[p]   = 8'($urandom);
    drive(p, 1'b1);
  endtask

  // Advance one cycle; the error flag follows abort-set, then clear, then hold
  task automatic tick(input bit abort);
    if (abort) err_exp = 1'b1;
    else if (err_clr) err_exp = 1'b0;
    @(negedge clk25);
    err_clr = ($urandom_range(0, 7) == 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_strobes"}, {bus.sdram_rd, bus.sdram_wr}, 2'b00);
    check({tag, "_acks"},    {bus.a_ack, bus.b_ack},       2'b00);
    check({tag, "_a_rdata"}, bus.a_rdata, rd_exp[0]);
    check({tag, "_b_rdata"}, bus.b_rdata, rd_exp[1]);
    check({tag, "_err"},     timeout_err, err_exp);
  endtask

  int         win;
  int         lat;
  int         hi;
  int         stray;
  int         exp_hi;
  bit         do_rst;
  bit         rst_hit;
  bit         timed;
  logic [7:0] dv;
  int         r;

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    bus.sdram_ready = 1'b0; bus.sdram_dout = 8'h00;
    for (int p = 0; p < 2; p++) begin
      pwe[p] = 1'b0; paddr[p] = '0; pwd[p] = '0; drive(p, 1'b0); rd_exp[p] = 8'h00;
    end
    last_b = 1'b1; err_exp = 1'b0; dv = 8'h00;
    repeat (2) @(negedge clk25);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", bus.sdram_addr, 16'h0000);
    check("rst_din",  bus.sdram_din,  8'h00);
    check_quiet("rst");
    rst = 1'b0;

    for (int n = 0; n < 250; n++) begin
      // IDLE cycle: nothing in flight, previous ack must have been a single pulse
      check("idle_busy", busy, 1'b0);
      check_quiet("idle");
      if (!bus.a_req && !bus.b_req) begin
        r = int'($urandom_range(0, 3));
        if (r == 1 || r == 3) arm(0);
        if (r == 2 || r == 3) arm(1);
      end
      bus.sdram_ready = ($urandom_range(0, 2) == 0);  // spurious in IDLE, must be ignored
      bus.sdram_dout  = 8'($urandom);
      if (!bus.a_req && !bus.b_req) begin
        tick(1'b0);
        continue;
      end

      win    = (bus.a_req && bus.b_req) ? (last_b ? 0 : 1) : (bus.a_req ? 0 : 1);
      last_b = (win == 1);
      do_rst = (n % 50 == 49);
      lat    = do_rst ? 4 : int'($urandom_range(1, T + 2));
      tick(1'b0);

      // First BUSY cycle: command presented from the granted port's latched fields
      check("busy_busy", busy, 1'b1);
      check("busy_addr", bus.sdram_addr, paddr[win]);
      check("busy_din",  bus.sdram_din,  pwd[win]);
      check("busy_rdwr", {bus.sdram_rd, bus.sdram_wr}, {!pwe[win], pwe[win]});
      if ($urandom_range(0, 3) == 0) drive(win, 1'b0);  // early drop must not cancel

      hi = 0; stray = 0; timed = 1'b0; rst_hit = 1'b0;
      for (int k = 1; k <= T; k++) begin
        if (bus.sdram_rd == !pwe[win] && bus.sdram_wr == pwe[win]) hi++;
        stray += int'(bus.a_ack) + int'(bus.b_ack);
        if (do_rst && k == 2) begin
          rst_hit = 1'b1;
          break;
        end
        bus.sdram_ready = (k == lat);
        bus.sdram_dout  = 8'($urandom);
        if (k == lat) dv = bus.sdram_dout;
        if (k == lat || k == T) begin
          timed = (k != lat);
          tick(timed);
          break;
        end
        tick(1'b0);
      end
      bus.sdram_ready = 1'b0;

      if (rst_hit) begin
        rst = 1'b1; err_clr = 1'b0;
        tick(1'b0);
        err_clr = 1'b0; err_exp = 1'b0; last_b = 1'b1;
        rd_exp[0] = 8'h00; rd_exp[1] = 8'h00;
        check("midrst_busy", busy, 1'b0);
        check("midrst_addr", bus.sdram_addr, 16'h0000);
        check_quiet("midrst");
        arm(0); arm(1);  // tie waiting at release must go to A
        tick(1'b0);
        err_clr = 1'b0; err_exp = 1'b0;
        check("midrst_noack", {bus.a_ack, bus.b_ack}, 2'b00);
        rst = 1'b0;
        continue;
      end

      // Ack cycle (RECOVER)
      exp_hi = (lat < T) ? lat : T;
      if (!pwe[win]) rd_exp[win] = timed ? 8'hFF : dv;
      check("strobe_cycles", hi, exp_hi);
      check("stray_ack", stray, 0);
      check("ack_port", {bus.a_ack, bus.b_ack}, (win == 0) ? 2'b10 : 2'b01);
      check("rec_strobes", {bus.sdram_rd, bus.sdram_wr}, 2'b00);
      check("rec_busy", busy, 1'b1);
      check("ack_a_rdata", bus.a_rdata, rd_exp[0]);
      check("ack_b_rdata", bus.b_rdata, rd_exp[1]);
      check("ack_err", timeout_err, err_exp);

      if ((win == 0 ? bus.a_req : bus.b_req) && ($urandom_range(0, 1) == 0)) arm(win);
      else drive(win, 1'b0);
      bus.sdram_ready = ($urandom_range(0, 2) == 0);  // spurious in RECOVER, must be ignored
      bus.sdram_dout  = 8'($urandom);
      tick(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
